bitstream_fetch_ctrl: RTL and testbench

Read-side controller for the encoded-bitstream RAM. It issues active-low read enables and word addresses to the 16-bit bitstream RAM and captures the returned words into a small prefetch FIFO. It presents the syntax parser with a left-aligned 16-bit bit window that advances by a variable 0..16 bits per cycle. It sits between the bitstream RAM and the bitstream parser/exp-Golomb decoders.

---
 rtl/bitstream_fetch_ctrl.sv | 163 ++++++++++++++++
 tb/tb_bitstream_fetch_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bitstream_fetch_ctrl.sv
// Read-side controller for the encoded-bitstream RAM.
// Issues active-low reads to the 16-bit bitstream RAM and keeps a small prefetch FIFO
// topped up. It presents the parser with a left-aligned 16-bit window that can advance
// by 0..16 bits per cycle.
module bitstream_fetch_ctrl #(
    parameter int FIFO_DEPTH = 4  // prefetch depth in words, 2..8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [16:0] start_addr,
    output logic        BitStream_ram_ren,
    output logic [16:0] BitStream_ram_addr,
    input  logic [15:0] BitStream_ram_data,
    output logic [15:0] bits_window,
    output logic        window_valid,
    input  logic [4:0]  consume_len,
    output logic        aligned
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR    = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [4:0]       DEPTH_LIMIT = 5'(FIFO_DEPTH);

    // Fetch side
    logic              running;         // a stream has been started since reset
    logic              ren;             // registered active-low read enable
    logic [16:0]       addrReg;         // address of the read currently on the bus
    logic [16:0]       nextAddr;        // address the next issued read will use
    logic              capturePending;  // RAM data for the current stream is on the bus

    // Prefetch FIFO
    logic [15:0]       fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [CNT_W-1:0]  fifoCount;

    // Bit buffer
    logic [31:0]       bitBuf;
    logic [5:0]        bitCount;
    logic [3:0]        bitOffset;

    // Per-cycle decisions
    logic [4:0]        consumeAmt;
    logic [5:0]        postCount;
    logic [31:0]       shiftedBuf;
    logic [31:0]       refillBits;
    logic              doPop;
    logic [31:0]       nextBuf;
    logic [5:0]        nextCount;
    logic [4:0]        reservedSlots;
    logic              doIssue;

    function automatic logic [PTR_W-1:0] bumpPtr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Consume-then-refill datapath and the prefetch issue decision
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        consumeAmt = 5'd0;
        if (bitCount >= 6'd16) begin
            consumeAmt = (consume_len > 5'd16) ? 5'd16 : consume_len;
        end
        postCount  = bitCount - {1'b0, consumeAmt};
        shiftedBuf = bitBuf << consumeAmt;
        doPop      = (postCount <= 6'd16) && (fifoCount != '0);
        // Popped word lands directly below the bits still held after the consume.
        refillBits = {fifoMem[rdPtr], 16'h0000} >> postCount;
        nextBuf    = doPop ? (shiftedBuf | refillBits) : shiftedBuf;
        nextCount  = doPop ? (postCount + 6'd16) : postCount;
        // Slots spoken for after this edge: stored words, the word on the RAM bus,
        // the read being sampled now, less the word leaving for the bit buffer.
        reservedSlots = 5'(fifoCount) + {4'd0, capturePending} + {4'd0, ~ren}
                        - {4'd0, doPop};
        doIssue = running && (reservedSlots < DEPTH_LIMIT);
    end

    // Read issue: registered ren/addr, one read per cycle while a slot is free
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples
        // pre-edge values regardless of block ordering.
        if (!reset_n) begin
            running  <= 1'b0;
            ren      <= 1'b1;
            addrReg  <= '0;
            nextAddr <= '0;
        end else if (start) begin
            running  <= 1'b1;
            ren      <= 1'b0;
            addrReg  <= start_addr;
            nextAddr <= start_addr + 17'd1;
        end else if (doIssue) begin
            ren      <= 1'b0;
            addrReg  <= nextAddr;
            nextAddr <= nextAddr + 17'd1;
        end else begin
            ren      <= 1'b1;
        end
    end

    // Capture tracking and FIFO pointers; start begins a new epoch so any
    // data returning from older reads is never marked for capture
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            capturePending <= 1'b0;
            wrPtr          <= '0;
            rdPtr          <= '0;
            fifoCount      <= '0;
        end else if (start) begin
            capturePending <= 1'b0;
            wrPtr          <= '0;
            rdPtr          <= '0;
            fifoCount      <= '0;
        end else begin
            capturePending <= ~ren;
            if (capturePending) begin
                wrPtr <= bumpPtr(wrPtr);
            end
            if (doPop) begin
                rdPtr <= bumpPtr(rdPtr);
            end
            case ({capturePending, doPop})
                2'b10:   fifoCount <= fifoCount + CNT_W'(1);
                2'b01:   fifoCount <= fifoCount - CNT_W'(1);
                default: fifoCount <= fifoCount;
            endcase
        end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        // NOTE: storage array is not reset; pointers and count define what is valid.
        if (capturePending && !start) begin
            fifoMem[wrPtr] <= BitStream_ram_data;
        end
    end

    // Bit buffer, fill count and bit offset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bitBuf    <= '0;
            bitCount  <= '0;
            bitOffset <= '0;
        end else if (start) begin
            bitBuf    <= '0;
            bitCount  <= '0;
            bitOffset <= '0;
        end else begin
            bitBuf    <= nextBuf;
            bitCount  <= nextCount;
            bitOffset <= bitOffset + consumeAmt[3:0];  // 16 wraps to 0
        end
    end

    assign BitStream_ram_ren  = ren;
    assign BitStream_ram_addr = addrReg;
    assign bits_window        = bitBuf[31:16];
    assign window_valid       = (bitCount >= 6'd16);
    assign aligned            = (bitOffset == 4'd0);

endmodule

// File: tb/tb_bitstream_fetch_ctrl.sv
// Self-checking bench for bitstream_fetch_ctrl. The reference model treats the stream
// as the RAM word sequence from the start address and tracks a bit position into it.
module tb_bitstream_fetch_ctrl;

    localparam int FIFO_DEPTH = 4;

    logic        clk;
    logic        resetN;
    logic        start;
    logic [16:0] startAddr;
    logic        ren;
    logic [16:0] addr;
    logic [15:0] ramData;
    logic [15:0] bitsWindow;
    logic        windowValid;
    logic [4:0]  consumeLen;
    logic        alignedOut;

    logic [15:0] ram [131072];

    int          nTests = 0;
    int          nFail  = 0;

    // Reference model state
    logic [16:0] base;
    int          pos;
    logic [16:0] expAddr;
    int          nReads;

    bitstream_fetch_ctrl #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk               (clk),
        .reset_n           (resetN),
        .start             (start),
        .start_addr        (startAddr),
        .BitStream_ram_ren (ren),
        .BitStream_ram_addr(addr),
        .BitStream_ram_data(ramData),
        .bits_window       (bitsWindow),
        .window_valid      (windowValid),
        .consume_len       (consumeLen),
        .aligned           (alignedOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM: data valid the cycle after ren was low
    always @(posedge clk) begin
        if (ren === 1'b0) ramData <= ram[addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] expWindow(input int p);
        logic [16:0] i0;
        logic [16:0] i1;
        logic [31:0] pair;
        i0   = 17'(int'(base) + p / 16);
        i1   = i0 + 17'd1;
        pair = {ram[i0], ram[i1]} << (p % 16);
        return pair[31:16];
    endfunction

    // Sample at the current negedge, drive consume_len, advance one cycle
    task automatic step(input logic [4:0] len);
        int c;
        c = (len > 5'd16) ? 16 : int'(len);
        if (ren === 1'b0) begin
            check("read_addr", 32'(addr), 32'(expAddr));
            expAddr = expAddr + 17'd1;
            nReads++;
        end
        if (windowValid === 1'b1) begin
            check("window", 32'(bitsWindow), 32'(expWindow(pos)));
            check("aligned", 32'(alignedOut), 32'((pos % 16) == 0));
            pos += c;
        end
        consumeLen = len;
        @(negedge clk);
    endtask

    task automatic startStream(input logic [16:0] a);
        start      = 1'b1;
        startAddr  = a;
        consumeLen = 5'd0;
        @(negedge clk);
        start   = 1'b0;
        base    = a;
        pos     = 0;
        expAddr = a;
        nReads  = 0;
    endtask

    task automatic waitValid(input string tag);
        int n;
        n = 0;
        while (windowValid !== 1'b1 && n < 10) begin
            step(5'd0);
            n++;
        end
        check(tag, 32'(n), 32'd3);
    endtask

    initial begin
        resetN     = 1'b0;
        start      = 1'b0;
        startAddr  = '0;
        consumeLen = '0;
        base       = '0;
        pos        = 0;
        expAddr    = '0;
        nReads     = 0;
        for (int i = 0; i < 131072; i++) ram[i] = 16'($urandom);
        ram[17'h10] = 16'h1234;
        ram[17'h11] = 16'hABCD;
        ram[17'h12] = 16'h5678;

        // Reset values
        #12;
        check("rst_ren", 32'(ren), 32'd1);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_valid", 32'(windowValid), 32'd0);
        check("rst_window", 32'(bitsWindow), 32'd0);
        check("rst_aligned", 32'(alignedOut), 32'd1);
        @(negedge clk);
        resetN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_ren", 32'(ren), 32'd1);
        end

        // Basic fetch
        startStream(17'h10);
        check("start_ren", 32'(ren), 32'd0);
        check("start_addr", 32'(addr), 32'h10);
        waitValid("basic_latency");
        check("basic_w0", 32'(bitsWindow), 32'h1234);
        check("basic_al0", 32'(alignedOut), 32'd1);
        step(5'd4);
        check("basic_w1", 32'(bitsWindow), 32'h234A);
        check("basic_al1", 32'(alignedOut), 32'd0);
        step(5'd12);
        check("basic_w2", 32'(bitsWindow), 32'hABCD);
        check("basic_al2", 32'(alignedOut), 32'd1);

        // Streaming at 16 bits per cycle
        step(5'd16);
        check("stream_w3", 32'(bitsWindow), 32'h5678);
        for (int i = 0; i < 8; i++) begin
            check("stream_valid", 32'(windowValid), 32'd1);
            check("stream_ren", 32'(ren), 32'd0);
            step(5'd16);
        end

        // Backpressure: FIFO plus 32 buffered bits, then reads stop
        for (int i = 0; i < 12; i++) step(5'd0);
        check("bp_ren", 32'(ren), 32'd1);
        check("bp_reads", 32'(nReads), 32'(pos / 16 + FIFO_DEPTH + 2));
        for (int i = 0; i < 3; i++) begin
            check("bp_addr_hold", 32'(addr), 32'(expAddr - 17'd1));
            step(5'd0);
        end
        for (int i = 0; i < 40; i++) begin
            check("resume_valid", 32'(windowValid), 32'd1);
            step(5'(16 + $urandom_range(0, 15)));
        end

        // Address wrap
        startStream(17'h1FFFF);
        waitValid("wrap_latency");
        for (int i = 0; i < 6; i++) begin
            check("wrap_valid", 32'(windowValid), 32'd1);
            step(5'd16);
        end
        check("wrap_reads", 32'(addr[16:4]), 32'd0);

        // Restart with reads in flight, including a back-to-back start
        startStream(17'h00123);
        step(5'd16);
        step(5'd16);
        startStream(17'h300);
        startStream(17'h200);
        waitValid("restart_latency");
        check("restart_w0", 32'(bitsWindow), 32'(ram[17'h200]));
        for (int i = 0; i < 5; i++) step(5'd16);

        // Randomized consumption, saturating lengths included
        for (int i = 0; i < 200; i++) begin
            check("rand_valid", 32'(windowValid), 32'd1);
            step(5'($urandom_range(0, 31)));
        end

        // Asynchronous reset mid-stream
        #2 resetN = 1'b0;
        #1;
        check("mid_rst_ren", 32'(ren), 32'd1);
        check("mid_rst_addr", 32'(addr), 32'd0);
        check("mid_rst_valid", 32'(windowValid), 32'd0);
        check("mid_rst_window", 32'(bitsWindow), 32'd0);
        check("mid_rst_aligned", 32'(alignedOut), 32'd1);
        @(negedge clk);
        resetN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_ren", 32'(ren), 32'd1);
            check("post_rst_valid", 32'(windowValid), 32'd0);
        end

        // Fresh random stream after reset
        startStream(17'($urandom));
        waitValid("rand_latency");
        for (int i = 0; i < 200; i++) begin
            check("rand2_valid", 32'(windowValid), 32'd1);
            step(5'($urandom_range(0, 31)));
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
